// File: rtl/full_adder_reg_pkg.sv
// full_adder_reg_pkg: shared constants for the registered ripple-carry adder
package full_adder_reg_pkg;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_reg_fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic in_carry,
    output logic sum,
    output logic out_carry
);
    assign sum       = a ^ b ^ in_carry;
    assign out_carry = (a & b) | (in_carry & (a ^ b));
endmodule

// File: rtl/full_adder_reg.sv
// full_adder_reg: ripple-carry adder of fa_cell instances with registered sum, carry and valid
module full_adder_reg
    import full_adder_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             out_carry,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = in_carry;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a        (a[i]),
            .b        (b[i]),
            .in_carry (carry[i]),
            .sum      (sum_comb[i]),
            .out_carry(carry[i+1])
        );
    end

    // result registers only load on accepted inputs so idle cycles hold the last sum
    always_ff @(posedge clock) begin
        if (reset) begin
            sum       <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= sum_comb;
                out_carry <= carry[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: scoreboard bench driving a 1-bit and an 8-bit instance side by side
module tb_full_adder_reg;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       s1, co1, ov1;
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       co8, ov8;

    int checks = 0;
    int failures = 0;
    logic [8:0] q1[$];
    logic [8:0] q8[$];
    logic [8:0] last1 = '0, last8 = '0;
    logic       rs, ev1, ev8;
    logic [1:0] tt[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    full_adder_reg #(.WIDTH(1)) d1 (
        .clock(clock), .reset(reset), .a(a1), .b(b1), .in_carry(c1), .in_valid(v1),
        .sum(s1), .out_carry(co1), .out_valid(ov1)
    );

    full_adder_reg #(.WIDTH(8)) d8 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .in_carry(c8), .in_valid(v8),
        .sum(s8), .out_carry(co8), .out_valid(ov8)
    );

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic p1(input logic v, input logic a, input logic b, input logic c, input logic [1:0] e);
        v1 = v; a1 = a; b1 = b; c1 = c;
        if (v && !reset) q1.push_back({7'b0, e});
    endtask

    task automatic p8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] e);
        v8 = v; a8 = a; b8 = b; c8 = c;
        if (v && !reset) q8.push_back(e);
    endtask

    // monitor: one edge separates each push from its pop
    always begin
        @(posedge clock);
        rs = reset;
        #1;
        if (rs) begin
            chk("w1_reset", {6'b0, ov1, co1, s1}, 9'd0);
            chk("w8_reset", {ov8, co8, s8}, 10'd0);
            last1 = '0; last8 = '0;
            q1.delete(); q8.delete();
        end else begin
            ev1 = q1.size() != 0;
            ev8 = q8.size() != 0;
            chk("w1_valid", {8'b0, ov1}, {8'b0, ev1});
            chk("w8_valid", {8'b0, ov8}, {8'b0, ev8});
            if (ev1) last1 = q1.pop_front();
            if (ev8) last8 = q8.pop_front();
            chk("w1_data", {7'b0, co1, s1}, last1);
            chk("w8_data", {co8, s8}, last8);
        end
    end

    initial begin
        logic       v, a, b, c;
        logic [7:0] ra, rb;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        p1(1, 0, 0, 0, 2'd0);
        @(negedge clock); p1(1, 0, 1, 0, 2'd1);
        @(negedge clock); p1(1, 1, 1, 0, 2'd2);
        @(negedge clock); p1(1, 0, 0, 0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); p1(1, i[2], i[1], i[0], tt[i]);
            if (i[0]) begin
                @(negedge clock); p1(0, 1, 1, 1, 2'd0);
                @(negedge clock); p1(0, 0, 1, 0, 2'd0);
            end
        end
        @(negedge clock); p1(0, 0, 0, 0, 2'd0); p8(1, 8'd255, 8'd1, 0, 9'd256);
        @(negedge clock); p8(1, 8'd200, 8'd100, 1, 9'd301);
        @(negedge clock); p8(1, 8'd17, 8'd25, 0, 9'd42);
        @(negedge clock); p8(0, 8'd99, 8'd99, 1, 9'd0);
        @(negedge clock);
        p1(1, 1, 1, 0, 2'd2); p8(1, 8'd10, 8'd20, 1, 9'd31);
        @(negedge clock);
        reset = 1'b1;
        p1(1, 1, 1, 0, 2'd2); p8(1, 8'd255, 8'd255, 1, 9'd511);
        @(negedge clock);
        reset = 1'b0;
        p1(0, 0, 0, 0, 2'd0); p8(0, 8'd0, 8'd0, 0, 9'd0);
        @(negedge clock); p1(1, 1, 0, 1, 2'd2); p8(1, 8'd128, 8'd128, 0, 9'd256);
        @(negedge clock); p1(0, 0, 0, 0, 2'd0); p8(0, 8'd0, 8'd0, 0, 9'd0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            v = 1'($urandom); a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            p1(v, a, b, c, 2'(a) + 2'(b) + 2'(c));
            v = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom); c = 1'($urandom);
            p8(v, ra, rb, c, 9'(ra) + 9'(rb) + 9'(c));
        end
        @(negedge clock); p1(0, 0, 0, 0, 2'd0); p8(0, 8'd0, 8'd0, 0, 9'd0);
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_adder_reg.md
# full_adder_reg

Registered full adder: adds two WIDTH-bit operands plus a carry-in and presents the sum and carry-out on registered outputs one clock after the inputs are sampled. With WIDTH=1 it is the classic one-bit full adder used as the arithmetic building block in the FPGA HDL examples. For wider WIDTH it chains one-bit cells as a ripple-carry adder for counters and accumulators. Operates in a single clock domain.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, default 1, operand and sum width in bits (≥1).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- in_carry  input  1  carry into bit 0.
- in_valid  input  1  qualifies a, b and in_carry for this cycle.
- sum  output  WIDTH  registered sum bits, (a + b + in_carry) mod 2^WIDTH.
- out_carry  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  high for one cycle per accepted input, with sum and out_carry.

## Operation

- Per bit i:
  - sum[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = in_carry; out_carry = c[WIDTH].
- Arithmetic is unsigned. {out_carry, sum} equals the exact WIDTH+1-bit result of a + b + in_carry. No overflow is lost.
- On a rising edge with reset=0 and in_valid=1:
  - sum and out_carry load the combinational result.
  - out_valid loads 1.
- On a rising edge with reset=0 and in_valid=0:
  - sum and out_carry hold their previous values.
  - out_valid loads 0.
- There is no backpressure. A new operand set is accepted every cycle in_valid is high.
- X/Z on inputs while in_valid=0 has no effect on outputs.

## Timing

- Latency: exactly 1 clock, from the edge sampling in_valid=1 to updated outputs after that same edge.
- Throughput: one addition per clock.
- Reset values (edge with reset=1): sum = 0, out_carry = 0, out_valid = 0.
- Reset has priority over in_valid. Inputs presented on a reset edge are discarded and never produce out_valid.
- Reset mid-stream: the result of the operand set accepted on the cycle before the reset edge is visible for exactly one cycle, then cleared.
- The combinational ripple path, WIDTH cells deep, must close timing within one clock period. No internal pipelining.

## Structure

- No shared package is required. DEFAULT_WIDTH = 1 may live in the common constants include.
- One sub-module, fa_cell:
  - Combinational one-bit full adder with ports a, b, in_carry, sum, out_carry.
  - Instantiated WIDTH times via generate, with carry chained from cell i to cell i+1.
- The top level holds only the generate chain plus the output register and valid flop.

## Test plan

- WIDTH=1, reset 2 cycles, then a=0, b=0, in_carry=0, in_valid=1 -> next cycle sum=0, out_carry=0, out_valid=1. During reset all outputs are 0.
- WIDTH=1 sequence, 0+1+0, then 1+1+0, then 0+0+0, one per cycle -> outputs (sum, out_carry) = (1,0), (0,1), (0,0) on consecutive cycles, each 1 cycle late.
- WIDTH=1 exhaustive: all 8 combinations of a, b, in_carry -> 1+1+1 gives (1,1), and every result matches the truth table. in_valid=0 cycles hold outputs and drop out_valid.
- WIDTH=8: a=255, b=1, in_carry=0 -> sum=0, out_carry=1. Then a=200, b=100, in_carry=1 -> sum=45, out_carry=1. Then a=17, b=25, in_carry=0 -> sum=42, out_carry=0.
- Reset mid-operation: present 1+1+0 with in_valid=1 and reset=1 on the same edge -> sum=0, out_carry=0, out_valid=0 the next cycle. Normal results resume one cycle after reset deasserts.
- Randomized WIDTH=8, 1000 cycles with random in_valid -> {out_carry, sum} equals a+b+in_carry from the previous accepted cycle.
